// File: rtl/pe_seq_ctrl.sv
// Tile sequencer for a stochastic PE array: CLR -> LOADW -> MAC -> FIN, with a bit-reversed weight RNG.
// Optional macro PE_SEQ_CTRL_EARLY_TERM_EN adds an early_stop input that cuts the MAC phase short.
module pe_seq_ctrl #(
  parameter int IWIDTH = 16,
  parameter int CWIDTH = 16,
  parameter int WLOAD  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CWIDTH-1:0] mac_len,
`ifdef PE_SEQ_CTRL_EARLY_TERM_EN
  input  logic              early_stop,
`endif
  output logic              busy,
  output logic              done,
  output logic              en_i,
  output logic              clr_i,
  output logic              en_w,
  output logic              clr_w,
  output logic              en_o,
  output logic              clr_o,
  output logic              mac_done,
  output logic [IWIDTH-1:0] randW,
  output logic [IWIDTH-1:0] randW_inv
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_LOADW,
    S_MAC,
    S_FIN
  } state_t;

  localparam logic [CWIDTH-1:0] WLOAD_LAST = CWIDTH'(WLOAD - 1);

  state_t            state, next_state;
  logic [CWIDTH-1:0] len_q;
  logic [CWIDTH-1:0] cnt;
  logic [CWIDTH-1:0] rng;
  logic              mac_stop;

  logic              busy_d, done_d, clr_d, en_w_d, mac_d;
  logic [IWIDTH-1:0] rng_rev;

`ifdef PE_SEQ_CTRL_EARLY_TERM_EN
  assign mac_stop = early_stop;
`else
  assign mac_stop = 1'b0;
`endif

  // NOTE: next_state is defaulted before the case so no path leaves it unassigned (no latch).
  always_comb begin
    next_state = state;
    unique case (state)
      S_IDLE:  if (start) next_state = S_CLR;
      S_CLR:   next_state = S_LOADW;
      S_LOADW: if (cnt == WLOAD_LAST) next_state = (len_q == '0) ? S_FIN : S_MAC;
      S_MAC:   if (cnt == len_q - CWIDTH'(1) || mac_stop) next_state = S_FIN;
      S_FIN:   next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // Outputs are decoded from next_state and registered so they line up with the state they belong to.
  always_comb begin
    busy_d = (next_state != S_IDLE);
    done_d = (next_state == S_FIN);
    clr_d  = (next_state == S_CLR);
    en_w_d = (next_state == S_LOADW);
    mac_d  = (next_state == S_MAC);
  end

  always_comb begin
    rng_rev = '0;
    for (int i = 0; i < IWIDTH; i++) rng_rev[i] = rng[IWIDTH-1-i];
  end

  // NOTE: all state and outputs use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      len_q     <= '0;
      cnt       <= '0;
      rng       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      en_i      <= 1'b0;
      clr_i     <= 1'b0;
      en_w      <= 1'b0;
      clr_w     <= 1'b0;
      en_o      <= 1'b0;
      clr_o     <= 1'b0;
      mac_done  <= 1'b0;
      randW     <= '0;
      randW_inv <= '0;
    end else begin
      state <= next_state;

      if (state == S_IDLE && start) len_q <= mac_len;

      if ((state == S_LOADW || state == S_MAC) && next_state == state) cnt <= cnt + CWIDTH'(1);
      else                                                           cnt <= '0;

      // rng indexes the MAC cycle being issued; randW carries its bit-reversed low bits.
      if (state == S_CLR)          rng <= '0;
      else if (next_state == S_MAC) rng <= rng + CWIDTH'(1);

      busy     <= busy_d;
      done     <= done_d;
      mac_done <= done_d;
      clr_i    <= clr_d;
      clr_w    <= clr_d;
      clr_o    <= clr_d;
      en_w     <= en_w_d;
      en_i     <= mac_d;
      en_o     <= mac_d;
      // The weight pair is only meaningful during MAC; both buses idle at zero elsewhere.
      randW     <= mac_d ? rng_rev : '0;
      randW_inv <= mac_d ? ~rng_rev : '0;
    end
  end

endmodule

// File: tb/tb_pe_seq_ctrl.sv
// Randomized self-checking bench for pe_seq_ctrl: every cycle of every tile is compared against
// an expected trace built from the tile's phase lengths (optionally with early_stop when the macro is set).
module tb_pe_seq_ctrl;

  localparam int IW = 4;
  localparam int CW = 8;
  localparam int WL = 4;
  localparam int OW = 9 + 2 * IW;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          early_stop;
  logic [CW-1:0] mac_len;
  logic          busy, done, en_i, clr_i, en_w, clr_w, en_o, clr_o, mac_done;
  logic [IW-1:0] randW, randW_inv;
  logic [OW-1:0] obs;

  int vectors     = 0;
  int miscompares = 0;

  pe_seq_ctrl #(.IWIDTH(IW), .CWIDTH(CW), .WLOAD(WL)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .mac_len   (mac_len),
`ifdef PE_SEQ_CTRL_EARLY_TERM_EN
    .early_stop(early_stop),
`endif
    .busy      (busy),
    .done      (done),
    .en_i      (en_i),
    .clr_i     (clr_i),
    .en_w      (en_w),
    .clr_w     (clr_w),
    .en_o      (en_o),
    .clr_o     (clr_o),
    .mac_done  (mac_done),
    .randW     (randW),
    .randW_inv (randW_inv)
  );

  always #5 clk = ~clk;

  assign obs = {busy, done, en_i, clr_i, en_w, clr_w, en_o, clr_o, mac_done, randW, randW_inv};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (busy,done,en_i,clr_i,en_w,clr_w,en_o,clr_o,mac_done,randW,randW_inv)",
               tag, got, exp);
    end
  endtask

  // Van der Corput weight for MAC cycle j, built digit by digit.
  function automatic int vdc(input int j);
    int v = j % (1 << IW);
    int r = 0;
    for (int i = 0; i < IW; i++) begin
      r = r * 2 + (v % 2);
      v = v / 2;
    end
    return r;
  endfunction

  // Expected outputs in cycle k (1 = CLR) of a tile with eff MAC cycles, n = total cycles.
  function automatic logic [OW-1:0] expect_vec(input int k, input int n, input int eff);
    logic clr, ew, mac, fin;
    int   rw, ri;
    clr = (k == 1);
    ew  = (k >= 2) && (k <= 1 + WL);
    mac = (k >= 2 + WL) && (k <= 1 + WL + eff);
    fin = (k == n);
    rw  = mac ? vdc(k - 2 - WL) : 0;
    ri  = mac ? ((1 << IW) - 1 - rw) : 0;
    return {1'b1, fin, mac, clr, ew, clr, mac, clr, fin, IW'(rw), IW'(ri)};
  endfunction

  // Called at a negedge in IDLE. stop_at: MAC cycle (1-based) carrying early_stop, or -1.
  // abort_k: cycle in which rst is raised, or 0. noise: random start/mac_len while busy.
  task automatic tile(input int len, input int stop_at, input bit noise, input int abort_k);
    int eff, n, m;
    eff = (stop_at >= 1 && stop_at < len) ? stop_at : len;
    n   = 2 + WL + eff;
    start   = 1'b1;
    mac_len = CW'(len);
    @(negedge clk);
    start = 1'b0;
    for (int k = 1; k <= n; k++) begin
      check($sformatf("len%0d_c%0d", len, k), 32'(obs), 32'(expect_vec(k, n, eff)));
      m = k - 1 - WL;
      if (m >= 1 && m <= eff) early_stop = (m == stop_at);
      else                    early_stop = 1'($urandom_range(0, 1));
      if (noise) begin
        start   = (k == n) ? 1'b1 : 1'($urandom_range(0, 1));
        mac_len = CW'($urandom);
      end
      if (k == abort_k) begin
        rst   = 1'b1;
        start = 1'($urandom_range(0, 1));
        @(negedge clk);
        check($sformatf("abort_len%0d_c%0d", len, k), 32'(obs), 32'd0);
        rst   = 1'b0;
        start = 1'b0;
        for (int j = 0; j < 3; j++) begin
          @(negedge clk);
          check($sformatf("post_abort_%0d", j), 32'(obs), 32'd0);
        end
        return;
      end
      @(negedge clk);
    end
    check($sformatf("idle_after_len%0d", len), 32'(obs), 32'd0);
    start      = 1'b0;
    early_stop = 1'b0;
  endtask

  initial begin
    int len, stop_at, abort_k;
    rst        = 1'b1;
    start      = 1'b0;
    early_stop = 1'b0;
    mac_len    = '0;
    repeat (3) begin
      @(negedge clk);
      check("reset", 32'(obs), 32'd0);
    end
    rst = 1'b0;
    @(negedge clk);
    check("idle_after_reset", 32'(obs), 32'd0);

    tile(8, -1, 1'b0, 0);               // 14-cycle tile
    tile(0, -1, 1'b0, 0);               // skip MAC, 6-cycle tile
    tile(4, -1, 1'b0, 0);               // randW 0,8,4,12
    tile(8, -1, 1'b1, 0);               // starts while busy are ignored
    tile(8, -1, 1'b0, 1 + WL + 3);      // reset on the 3rd MAC cycle
    tile(5, -1, 1'b0, 0);               // normal tile after abort
    tile(255, -1, 1'b0, 0);             // longest length, RNG wraps low bits

    // rst and start together: start dropped.
    rst     = 1'b1;
    start   = 1'b1;
    mac_len = CW'(5);
    @(negedge clk);
    check("rst_start_same_cycle", 32'(obs), 32'd0);
    rst   = 1'b0;
    start = 1'b0;
    @(negedge clk);
    check("start_dropped", 32'(obs), 32'd0);

`ifdef PE_SEQ_CTRL_EARLY_TERM_EN
    tile(100, 5, 1'b0, 0);
`endif

    for (int t = 0; t < 30; t++) begin
      len = $urandom_range(0, 40);
`ifdef PE_SEQ_CTRL_EARLY_TERM_EN
      stop_at = $urandom_range(1, 45);
`else
      stop_at = -1;
`endif
      abort_k = ($urandom_range(0, 5) == 0) ? $urandom_range(1, 2 + WL + len) : 0;
      tile(len, stop_at, 1'b1, abort_k);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pe_seq_ctrl.md
PE_SEQ_CTRL -- requirements
Module: pe_seq_ctrl

Interface
REQ-001 Parameter IWIDTH, default 16: width of the weight random-number bus.
REQ-002 Parameter CWIDTH, default 16: width of the MAC-length field and cycle counter.
REQ-003 Parameter WLOAD, default 16: number of weight-load cycles, equal to array rows; range 1..2^CWIDTH-1.
REQ-004 The block SHALL have one clock; reset is synchronous and active-high.
REQ-005 clk  input  1  clock; all state updates on the rising edge.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 start  input  1  single-cycle request to run one tile.
REQ-008 mac_len  input  CWIDTH  number of stochastic MAC bit-cycles; sampled when start is accepted.
REQ-009 busy  output  1  high in every state except IDLE.
REQ-010 done  output  1  one-cycle pulse at tile completion.
REQ-011 en_i, clr_i, en_w, clr_w, en_o, clr_o  output  1 each  enable/clear to PE-array column 0.
REQ-012 mac_done  output  1  accumulator hand-off strobe to PE-array column 0.
REQ-013 randW  output  IWIDTH  weight random number to the array edge.
REQ-014 randW_inv  output  IWIDTH  bitwise complement of randW.

Function
REQ-015 FSM states are IDLE, CLR, LOADW, MAC and FIN; all outputs SHALL be registered.
REQ-016 IDLE: when start=1, latch mac_len into len_q and go to CLR next cycle; otherwise stay in IDLE.
REQ-017 CLR: clr_i=clr_w=clr_o=1 for exactly one cycle, zero the cycle counter and the RNG counter, then go to LOADW.
REQ-018 LOADW: en_w=1 for exactly WLOAD consecutive cycles; then go to MAC, or to FIN if len_q=0.
REQ-019 MAC: en_i=en_o=1 for exactly len_q consecutive cycles; then go to FIN.
REQ-020 FIN: mac_done=1 and done=1 for exactly one cycle; then go to IDLE.
REQ-021 Outside its own state, each enable, clear and strobe SHALL be 0.
REQ-022 RNG: a CWIDTH-bit counter increments once per MAC cycle and wraps modulo 2^CWIDTH.
REQ-023 randW SHALL equal the bit-reversed low IWIDTH bits of the RNG counter (van der Corput sequence), and SHALL be 0 outside MAC.
REQ-024 A start while busy=1 SHALL be ignored and SHALL NOT alter len_q.
REQ-025 Total tile latency, from the start-accept edge to the done pulse, SHALL be 1+WLOAD+len_q+1 cycles.
REQ-026 A start in the cycle done=1 SHALL be ignored; a new tile may be accepted in the following IDLE cycle.

Reset
REQ-027 When rst=1 at a clock edge, the block SHALL go to IDLE and zero len_q, the cycle counter and the RNG counter.
REQ-028 During reset, every output SHALL be 0; busy=0 and done=0.
REQ-029 A reset in any state, including mid-MAC, SHALL abort the tile with no done or mac_done pulse.
REQ-030 If rst and start are both high in the same cycle, rst SHALL take priority and start SHALL be dropped.

Configuration
REQ-031 Macro PE_SEQ_CTRL_EARLY_TERM_EN, when defined, SHALL add input port early_stop (1 bit).
REQ-032 With the macro defined, early_stop=1 during MAC SHALL make that cycle the last MAC cycle, with FIN on the next cycle; early_stop SHALL be ignored in every other state.
REQ-033 Without the macro, the early_stop port SHALL NOT exist and MAC SHALL always run the full len_q cycles.

Verification
REQ-034 WLOAD=4, start with mac_len=8 -> CLR 1 cycle, en_w 4 cycles, en_i/en_o 8 cycles, mac_done+done on cycle 14 after accept.
REQ-035 mac_len=0 -> en_i never asserted; done exactly 6 cycles after accept (WLOAD=4).
REQ-036 IWIDTH=4, mac_len=4 -> randW sequence 0,8,4,12 and randW_inv sequence 15,7,11,3.
REQ-037 start pulsed during LOADW with mac_len=3 -> ignored; MAC still runs the originally latched length.
REQ-038 rst asserted on the 3rd MAC cycle -> all outputs 0 next cycle, no done pulse, next start behaves normally.
REQ-039 With PE_SEQ_CTRL_EARLY_TERM_EN, mac_len=100, early_stop on the 5th MAC cycle -> exactly 5 en_o cycles, then done.
